// File: rtl/control_unit.sv
// Control unit: FETCH/EXEC sequencer for the single-cycle datapath, decoding opcode[15:12] into datapath strobes.
// Latency: one instruction per two cycles; EXEC strobes are combinational from opcode/flags; halts on HALT or stack fault.
module control_unit #(
    parameter int STACK_DEPTH = 16,
    parameter int SP_W        = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] opcode,
    input  logic        z,
    input  logic        carry,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic        push,
    output logic        pop,
    output logic [2:0]  op_alu,
    output logic        pc_en,
    output logic        halted,
    output logic        stack_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [3:0] C_NOP  = 4'b0000;
    localparam logic [3:0] C_ALU  = 4'b0001;
    localparam logic [3:0] C_LI   = 4'b0010;
    localparam logic [3:0] C_J    = 4'b0011;
    localparam logic [3:0] C_JZ   = 4'b0100;
    localparam logic [3:0] C_JNZ  = 4'b0101;
    localparam logic [3:0] C_JC   = 4'b0110;
    localparam logic [3:0] C_JNC  = 4'b0111;
    localparam logic [3:0] C_CALL = 4'b1000;
    localparam logic [3:0] C_RET  = 4'b1001;
    localparam logic [3:0] C_HALT = 4'b1111;

    localparam logic [SP_W-1:0] DEPTH_MAX = SP_W'(STACK_DEPTH);

    state_t          state;
    logic [SP_W-1:0] depth;
    logic [3:0]      cls;
    logic            stack_full;
    logic            stack_empty;
    logic            overflow;
    logic            underflow;
    logic            unused_bits;

    assign cls         = opcode[15:12];
    assign stack_full  = (depth >= DEPTH_MAX);
    assign stack_empty = (depth == '0);
    assign unused_bits = ^{opcode[11], opcode[7:0]};

    assign overflow  = (state == EXEC) && (cls == C_CALL) && stack_full;
    assign underflow = (state == EXEC) && (cls == C_RET)  && stack_empty;
    assign halted    = (state == HALT);

    // FETCH and HALT share the idle strobe pattern, which is also the reset pattern.
    always_comb begin
        s_inc  = 1'b1;
        s_inm  = 1'b0;
        we3    = 1'b0;
        wez    = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        op_alu = 3'b000;
        pc_en  = 1'b0;
        if (state == EXEC) begin
            pc_en = 1'b1;
            case (cls)
                C_NOP: ;
                C_ALU: begin
                    we3    = 1'b1;
                    wez    = 1'b1;
                    op_alu = opcode[10:8];
                end
                C_LI: begin
                    we3   = 1'b1;
                    s_inm = 1'b1;
                end
                C_J:   s_inc = 1'b0;
                C_JZ:  s_inc = ~z;
                C_JNZ: s_inc = z;
                C_JC:  s_inc = ~carry;
                C_JNC: s_inc = carry;
                C_CALL: begin
                    if (stack_full) begin
                        pc_en = 1'b0;
                    end else begin
                        push  = 1'b1;
                        s_inc = 1'b0;
                    end
                end
                C_RET: begin
                    if (stack_empty) pc_en = 1'b0;
                    else             pop   = 1'b1;
                end
                C_HALT: pc_en = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            depth     <= '0;
            stack_err <= 1'b0;
        end else begin
            case (state)
                FETCH: state <= EXEC;
                EXEC: begin
                    if (overflow || underflow) begin
                        stack_err <= 1'b1;
                        state     <= HALT;
                    end else if (cls == C_HALT) begin
                        state <= HALT;
                    end else begin
                        state <= FETCH;
                    end
                    if (push)     depth <= depth + SP_W'(1);
                    else if (pop) depth <= depth - SP_W'(1);
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule
